opb_register_bank_ppc2simulink: RTL and testbench

//  OPB slave exposing C_NUM_REGS software-writable 32-bit control registers to fabric logic.
//  - Each register has byte-enable writes, readback, a per-register write strobe and optional self-clear.
//  - Successor to the single-register ppc2simulink block, for snap/vacc control banks; sits on the PPC OPB bus.
//  - Single clock domain: fabric consumers run on OPB_Clk.

---
 rtl/opb_reg_pkg.sv | 29 ++
 rtl/opb_reg_lane.sv | 95 +++++++++
 rtl/opb_register_bank_ppc2simulink.sv | 156 +++++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_reg_pkg.sv
// Shared definitions for the OPB control-register bank: FSM encoding,
// bus geometry constants and the byte-enable to user-bit lane map.
package opb_reg_pkg;

  localparam int OPB_BE_W = 4;
  localparam int REG_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } opb_state_e;

  // OPB numbers bits big-endian: BE[0] covers DBus[0:7], which is user bits [31:24].
  function automatic int lane_lo(input int k);
    return (OPB_BE_W - 1 - k) * 8;
  endfunction

  // Expand OPB byte enables into a per-bit write mask in user bit order.
  function automatic logic [REG_W-1:0] be_to_mask(input logic [0:OPB_BE_W-1] be);
    logic [REG_W-1:0] mask;
    mask = '0;
    for (int k = 0; k < OPB_BE_W; k++) begin
      mask[lane_lo(k) +: 8] = {8{be[k]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/opb_reg_lane.sv
// One control register of the bank: byte-masked write, optional self-clear
// and a write strobe one cycle after the visible value changes.
// With SHADOW_COMMIT_EN defined, bus writes land in a shadow copy that is
// only transferred to the fabric output when the bank-wide commit fires.
module opb_reg_lane
  import opb_reg_pkg::*;
#(
  parameter logic [REG_W-1:0] RESET_VAL  = '0,
  parameter bit               SELF_CLEAR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [REG_W-1:0] wr_data,
  input  logic [REG_W-1:0] wr_mask,
  input  logic             commit,
  output logic [REG_W-1:0] data_out,
  output logic [REG_W-1:0] rd_data,
  output logic             wr_strobe
);

  logic [REG_W-1:0] data_q, data_d;
  logic             upd_q, upd_d;      // fabric output changed on the last edge
  logic             clr_q, clr_d;      // self-clear pending for this cycle
  logic             strobe_q, strobe_d;

`ifdef SHADOW_COMMIT_EN
  logic [REG_W-1:0] shadow_q, shadow_d;
  logic             dirty_q, dirty_d;

  // Next-state: bus writes go to the shadow; commit copies shadow to the output.
  always_comb begin
    // NOTE: every variable gets a default first so no branch can infer a latch.
    shadow_d = shadow_q;
    dirty_d  = dirty_q & ~commit;
    data_d   = data_q;
    if (wr_en) begin
      shadow_d = (shadow_q & ~wr_mask) | (wr_data & wr_mask);
      dirty_d  = 1'b1;
    end
    if (SELF_CLEAR && clr_q) data_d = RESET_VAL;
    // A commit landing on the clear cycle takes priority over the clear.
    if (commit) data_d = shadow_q;
    clr_d    = commit;
    upd_d    = commit & dirty_q;
    strobe_d = upd_q;
  end

  assign rd_data = shadow_q;
`else
  logic unused_commit;
  assign unused_commit = commit;

  // Next-state: bus writes update the fabric output directly.
  always_comb begin
    data_d = data_q;
    if (SELF_CLEAR && clr_q) data_d = RESET_VAL;
    // A write landing on the clear cycle takes priority over the clear.
    if (wr_en) data_d = (data_q & ~wr_mask) | (wr_data & wr_mask);
    clr_d    = wr_en;
    upd_d    = wr_en;
    strobe_d = upd_q;
  end

  assign rd_data = data_q;
`endif

  // Register state; every flop, shadow included, returns to a known value on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= RESET_VAL;
      upd_q    <= 1'b0;
      clr_q    <= 1'b0;
      strobe_q <= 1'b0;
`ifdef SHADOW_COMMIT_EN
      shadow_q <= RESET_VAL;
      dirty_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the values from before this edge.
      data_q   <= data_d;
      upd_q    <= upd_d;
      clr_q    <= clr_d;
      strobe_q <= strobe_d;
`ifdef SHADOW_COMMIT_EN
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign wr_strobe = strobe_q;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS 32-bit software-writable control registers
// to fabric logic on OPB_Clk. Optional feature macro: SHADOW_COMMIT_EN
// (writes staged in shadows, applied together by a write to slot C_NUM_REGS).
module opb_register_bank_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0104_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0104_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [31:0] C_RESET_VAL  = 32'h0,
  parameter logic [31:0] C_PULSE_MASK = 32'h0,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
  input  logic [0:OPB_BE_W-1]        OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic                       Sl_xferAck,
  output logic [C_NUM_REGS*32-1:0]   user_data_out,
  output logic [C_NUM_REGS-1:0]      user_wr_strobe
);

  localparam int IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

  if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32 || C_NUM_REGS < 1 || C_NUM_REGS > 32
      || C_FAMILY == "") begin : g_bad_cfg
    $error("opb_register_bank_ppc2simulink: unsupported parameter set");
  end

  // Address decode. Big-endian bus vectors map MSB-first onto user order.
  logic [31:0] addr, off, slot;
  logic        in_range, hit, is_reg, is_commit;
  logic        unused_ok;

  assign addr      = OPB_ABus;
  assign off       = addr - C_BASEADDR;
  assign slot      = {2'b00, off[31:2]};
  assign in_range  = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign hit       = OPB_select && in_range;
  assign is_reg    = slot < 32'(C_NUM_REGS);
`ifdef SHADOW_COMMIT_EN
  assign is_commit = slot == 32'(C_NUM_REGS);
`else
  assign is_commit = 1'b0;
`endif
  assign unused_ok = OPB_seqAddr ^ off[1] ^ off[0];

  // Transfer state, captured when the FSM accepts a request.
  opb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                rnw_q, rnw_d;
  logic [0:OPB_BE_W-1] be_q, be_d;
  logic [REG_W-1:0]    wdata_q, wdata_d;
  logic                is_reg_q, is_reg_d;
  logic                commit_q, commit_d;

  // Next-state: IDLE accepts a hit, ACK lasts one cycle, HOLD absorbs a held select.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rnw_d    = rnw_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    is_reg_d = is_reg_q;
    commit_d = commit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d  = ST_ACK;
          idx_d    = slot[IDX_W-1:0];
          rnw_d    = OPB_RNW;
          be_d     = OPB_BE;
          wdata_d  = OPB_DBus;
          is_reg_d = is_reg;
          commit_d = is_commit;
        end
      end
      ST_ACK:  state_d = OPB_select ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (!OPB_select) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and captured-request registers.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      rnw_q    <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      is_reg_q <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rnw_q    <= rnw_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      is_reg_q <= is_reg_d;
      commit_q <= commit_d;
    end
  end

  logic             ack, wr_fire, commit_fire;
  logic [REG_W-1:0] wr_mask, rd_word;
  logic [REG_W-1:0] rd_bank [C_NUM_REGS];

  assign ack         = (state_q == ST_ACK);
  assign wr_fire     = ack && !rnw_q && is_reg_q;
  assign commit_fire = ack && !rnw_q && commit_q && wdata_q[0];
  assign wr_mask     = be_to_mask(be_q);

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_lane
    opb_reg_lane #(
      .RESET_VAL  (C_RESET_VAL),
      .SELF_CLEAR (C_PULSE_MASK[i])
    ) u_lane (
      .clk       (OPB_Clk),
      .rst       (OPB_Rst),
      .wr_en     (wr_fire && (idx_q == IDX_W'(i))),
      .wr_data   (wdata_q),
      .wr_mask   (wr_mask),
      .commit    (commit_fire),
      .data_out  (user_data_out[32*i +: 32]),
      .rd_data   (rd_bank[i]),
      .wr_strobe (user_wr_strobe[i])
    );
  end

  // Read mux over the lanes; only meaningful when the captured index is a register.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (idx_q == IDX_W'(i)) rd_word = rd_bank[i];
    end
  end

  // Bus responses; data bus is forced to zero outside a valid read ack.
  assign Sl_xferAck = ack;
  assign Sl_errAck  = ack && !is_reg_q && !commit_q;
  assign Sl_DBus    = (ack && rnw_q && is_reg_q) ? rd_word : '0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench for the OPB register bank (default build).
// Expected bus responses go to a scoreboard queue when a transfer is driven
// and are compared by a monitor when Sl_xferAck appears.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h0104_0000;
  localparam logic [31:0] RV   = 32'hA5A5_0001;
  localparam int          NREG = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw, sel, seq;
  logic [0:31] sl_dbus;
  logic        sl_err, sl_retry, sl_tout, sl_ack;
  logic [NREG*32-1:0] udo;
  logic [NREG-1:0]    ustb;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR   (BASE),
    .C_HIGHADDR   (32'h0104_00FF),
    .C_NUM_REGS   (NREG),
    .C_RESET_VAL  (RV),
    .C_PULSE_MASK (32'h8)
  ) dut (
    .OPB_Clk        (clk),
    .OPB_Rst        (rst),
    .OPB_ABus       (abus),
    .OPB_BE         (be),
    .OPB_DBus       (dbus),
    .OPB_RNW        (rnw),
    .OPB_select     (sel),
    .OPB_seqAddr    (seq),
    .Sl_DBus        (sl_dbus),
    .Sl_errAck      (sl_err),
    .Sl_retry       (sl_retry),
    .Sl_toutSup     (sl_tout),
    .Sl_xferAck     (sl_ack),
    .user_data_out  (udo),
    .user_wr_strobe (ustb)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] exp_reg [NREG];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          ack_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [0:3] b);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[31-8*k -: 8] = nw[31-8*k -: 8];
    return r;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREG; i++)
      check($sformatf("%s_reg%0d", tag, i), udo[32*i +: 32], exp_reg[i]);
  endtask

  // Monitor: pop scoreboard on every ack; data bus and errAck must be idle otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      if (sl_ack) begin
        ack_cnt++;
        if (sb_q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
        else begin
          mon_e = sb_q.pop_front();
          check({mon_e.tag, "_err"}, {31'd0, sl_err}, {31'd0, mon_e.err});
          check({mon_e.tag, "_data"}, sl_dbus, mon_e.data);
        end
      end else if (sel) begin
        check("dbus_idle", sl_dbus, 32'd0);
        check("erracK_idle", {31'd0, sl_err}, 32'd0);
      end
    end
  end

  // One OPB beat; select stays up through the commit edge plus 'hold' cycles.
  task automatic bus_xfer(input string tag, input logic [31:0] a, input logic r,
                          input logic [0:3] b, input logic [31:0] d,
                          input logic exp_err, input logic [31:0] exp_rd, input int hold);
    exp_t e;
    int   n;
    bit   got;
    @(posedge clk); #1;
    abus = a; rnw = r; be = b; dbus = d; sel = 1'b1;
    e.tag = tag; e.err = exp_err; e.data = exp_rd;
    sb_q.push_back(e);
    got = 1'b0;
    n   = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      got = sl_ack;
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      sb_q.delete(sb_q.size() - 1);
    end else begin
      check({tag, "_lat"}, n, 32'd2);
    end
    repeat (hold + 1) @(posedge clk);
    #1;
    sel = 1'b0; rnw = 1'b0; dbus = '0; be = '0;
  endtask

  // Present an address the slave must ignore and confirm no ack appears.
  task automatic no_ack_probe(input string tag, input logic [31:0] a);
    int a0;
    a0 = ack_cnt;
    @(posedge clk); #1;
    abus = a; rnw = 1'b1; be = 4'hF; sel = 1'b1;
    repeat (6) @(posedge clk);
    #1 sel = 1'b0;
    @(posedge clk); #1;
    check(tag, ack_cnt - a0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    rst = 1'b1; sel = 1'b0; seq = 1'b0; rnw = 1'b0;
    abus = '0; be = '0; dbus = '0;
    for (int i = 0; i < NREG; i++) exp_reg[i] = RV;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_regs("rst");
    check("rst_ack", {31'd0, sl_ack}, 32'd0);
    check("rst_err", {31'd0, sl_err}, 32'd0);
    check("rst_dbus", sl_dbus, 32'd0);
    check("rst_retry_tout", {30'd0, sl_retry, sl_tout}, 32'd0);
    check("rst_strobe", {28'd0, ustb}, 32'd0);
    rst = 1'b0;

    // Full-word write to reg1, strobe one cycle after the output update
    bus_xfer("wr1", BASE + 32'h4, 1'b0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'd0, 0);
    exp_reg[1] = 32'hDEAD_BEEF;
    check_regs("wr1");
    check("wr1_stb0", {28'd0, ustb}, 32'd0);
    @(posedge clk); #1;
    check("wr1_stb1", {28'd0, ustb}, 32'b0010);
    @(posedge clk); #1;
    check("wr1_stb2", {28'd0, ustb}, 32'd0);
    bus_xfer("rd1", BASE + 32'h4, 1'b1, 4'b1111, 32'd0, 1'b0, 32'hDEAD_BEEF, 0);

    // Byte-lane writes: BE[2] -> bits [15:8], BE[0] -> bits [31:24]
    bus_xfer("wr0_be2", BASE, 1'b0, 4'b0010, 32'h1122_3344, 1'b0, 32'd0, 0);
    exp_reg[0] = merge(exp_reg[0], 32'h1122_3344, 4'b0010);
    check("wr0_be2_val", udo[31:0], 32'hA5A5_3301);
    bus_xfer("wr0_be0", BASE, 1'b0, 4'b1000, 32'hCC00_0000, 1'b0, 32'd0, 0);
    exp_reg[0] = merge(exp_reg[0], 32'hCC00_0000, 4'b1000);
    check_regs("wr0_be0");
    bus_xfer("rd0", BASE, 1'b1, 4'b1111, 32'd0, 1'b0, exp_reg[0], 0);

    // BE=0000: acked, no data change, strobe still pulses
    bus_xfer("wr2_nobe", BASE + 32'h8, 1'b0, 4'b0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 0);
    check_regs("wr2_nobe");
    @(posedge clk); #1;
    check("wr2_nobe_stb", {28'd0, ustb}, 32'b0100);

    // Held select on a read: exactly one ack
    a0 = ack_cnt;
    bus_xfer("rd1_held", BASE + 32'h4, 1'b1, 4'b1111, 32'd0, 1'b0, 32'hDEAD_BEEF, 5);
    repeat (2) @(posedge clk);
    #1;
    check("held_ack_count", ack_cnt - a0, 32'd1);

    // Low address bits ignored
    bus_xfer("rd1_unaligned", BASE + 32'h6, 1'b1, 4'b1111, 32'd0, 1'b0, 32'hDEAD_BEEF, 0);

    // Out-of-range index inside the decoded window: error ack, no change
    bus_xfer("rd_oor", BASE + 32'hF0, 1'b1, 4'b1111, 32'd0, 1'b1, 32'd0, 0);
    bus_xfer("wr_oor", BASE + 32'hF0, 1'b0, 4'b1111, 32'hFFFF_FFFF, 1'b1, 32'd0, 0);
    bus_xfer("wr_slot4", BASE + 32'h10, 1'b0, 4'b1111, 32'h0000_0001, 1'b1, 32'd0, 0);
    check_regs("oor");

    // Outside the decoded window: no response at all
    no_ack_probe("above_high", 32'h0104_0100);
    no_ack_probe("below_base", 32'h0103_FFFC);

    // Self-clearing last register
    bus_xfer("wr3_pulse", BASE + 32'hC, 1'b0, 4'b1111, 32'h0000_0001, 1'b0, 32'd0, 0);
    check("wr3_pulse_set", udo[127:96], 32'h0000_0001);
    @(posedge clk); #1;
    check("wr3_pulse_clr", udo[127:96], RV);
    check("wr3_pulse_stb", {28'd0, ustb}, 32'b1000);
    bus_xfer("rd3", BASE + 32'hC, 1'b1, 4'b1111, 32'd0, 1'b0, RV, 0);

    // Reset asserted during the ack cycle aborts the write
    a0 = 0;
    @(posedge clk); #1;
    abus = BASE + 32'h8; rnw = 1'b0; be = 4'b1111; dbus = 32'h1234_5678; sel = 1'b1;
    begin
      exp_t e;
      e.tag = "wr2_abort"; e.err = 1'b0; e.data = 32'd0;
      sb_q.push_back(e);
    end
    while (!sl_ack && a0 < 8) begin
      @(negedge clk);
      a0++;
    end
    check("abort_saw_ack", {31'd0, sl_ack}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_ack_low", {31'd0, sl_ack}, 32'd0);
    sel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    if (sb_q.size() != 0) sb_q.delete(0);
    for (int i = 0; i < NREG; i++) exp_reg[i] = RV;
    repeat (2) @(posedge clk);
    #1;
    check_regs("abort");

    // Recovery after reset
    bus_xfer("wr0_post", BASE, 1'b0, 4'b1111, 32'h0BAD_F00D, 1'b0, 32'd0, 0);
    exp_reg[0] = 32'h0BAD_F00D;
    check_regs("post");
    bus_xfer("rd0_post", BASE, 1'b1, 4'b1111, 32'd0, 1'b0, 32'h0BAD_F00D, 0);

    repeat (2) @(posedge clk);
    check("sb_drain", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
